stopwatch_mmss: RTL and testbench
=================================

Name: stopwatch_mmss

Overview:
- Downstream consumer of the one-second clock generator's output.
- Samples the 1 Hz square wave (tick_in) in the system clock domain and counts elapsed time in BCD, MM:SS.
- Start/stop and clear controls come from debounced board keys.
- Drives four active-low seven-segment digits (HEX3..HEX0) plus status flags.

Parameters:
- MAX_MINUTES, 59: highest minute value shown. The count after MAX_MINUTES:59 wraps to 00:00.
- SYNC_STAGES, 2: number of synchroniser flops on tick_in. Legal values are 2 or 3.

Ports:
- clk  input  1  system clock, 50 MHz on board.
- reset  input  1  asynchronous, active-low reset.
- tick_in  input  1  1 Hz square wave from the one-second clock generator. Each rising edge is one second.
- start_stop  input  1  active-high level from a debounced key. Each rising edge toggles run/pause.
- clear  input  1  active-high level from a debounced key. A rising edge returns the block to 00:00 idle.
- hex0  output  7  seconds-ones segments, active-low, bit order {g,f,e,d,c,b,a}.
- hex1  output  7  seconds-tens segments.
- hex2  output  7  minutes-ones segments.
- hex3  output  7  minutes-tens segments.
- running  output  1  high while in the RUN state.
- wrap_pulse  output  1  one-clk pulse when the count rolls over from MAX_MINUTES:59 to 00:00.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; all four BCD digits = 0.
  - Synchroniser and edge-detect flops = 0.
  - running=0, wrap_pulse=0.
  - hex0..hex3 = 7'b1000000, which displays "0".
- Tick synchronisation:
  - tick_in passes through SYNC_STAGES flops, then one more "previous" flop.
  - sec_pulse = sync_last & ~prev. It is one clk wide per tick_in rising edge.
  - Latency: digits update on the (SYNC_STAGES+1)th clk edge after tick_in rises, i.e. 3 clk at the default.
- Control edge detection:
  - start_stop and clear each pass through a 2-flop synchroniser plus a prev flop, giving one-clk pulses ss_pulse and clr_pulse.
  - Holding a key high produces only one pulse.
- State machine (IDLE, RUN, PAUSED):
  - IDLE + ss_pulse -> RUN.
  - RUN + ss_pulse -> PAUSED.
  - PAUSED + ss_pulse -> RUN.
  - Any state + clr_pulse -> IDLE, and all digits are zeroed on the same edge.
- Priority: clr_pulse beats ss_pulse and sec_pulse in the same cycle. The result is IDLE, 00:00, no increment.
- Counting:
  - The count increments only when the current state is RUN and sec_pulse=1.
  - If ss_pulse (RUN->PAUSED) and sec_pulse arrive in the same cycle, the second is counted and the state then becomes PAUSED.
  - Ticks in IDLE or PAUSED are dropped; they are not queued.
- BCD arithmetic:
  - sec_ones counts 0..9, and its carry increments sec_tens.
  - sec_tens counts 0..5, and its carry increments the minutes.
  - Minutes are held as two BCD digits (min_tens, min_ones) and run 00..MAX_MINUTES.
  - Wrap: MAX_MINUTES:59 + 1 -> 00:00, with wrap_pulse=1 for exactly that cycle. The state stays RUN.
  - MAX_MINUTES must be 1..99. Digits never hold non-BCD values.
- running = (state==RUN). It is registered, so it changes on the same edge as the state.
- Seven-segment decode:
  - Combinational from the digit registers, active-low.
  - 0..9 use the standard patterns; for example 1 = 7'b1111001 and 8 = 7'b0000000.
  - Any value above 9 decodes to all-off (7'h7F). This is defensive only and is unreachable.
- Reset mid-run: the asynchronous return to the reset values above is immediate and does not wait for a clk edge.

Optional Feature:
- Macro: STOPWATCH_LAP_EN.
- With it defined:
  - Adds input lap (active-high, synchronised and edge-detected like clear) and output lap_active (1 bit, reset 0).
  - A lap pulse in RUN freezes hex0..hex3 at the current digits and sets lap_active=1. Internal counting continues.
  - A second lap pulse, or any clr_pulse, releases the freeze and sets lap_active=0. The display then shows the live count on the next cycle.
  - Lap pulses in IDLE or PAUSED are ignored.
  - clr_pulse releases the lap freeze as well as clearing the count.
- Without it: no lap port, no lap_active port; the displays always show the live digits.

Test Plan:
- Reset, then 3 tick_in rising edges with no start -> digits stay 00:00; hex0 = 7'b1000000; running=0.
- start_stop pulse, then 75 ticks -> display 01:15; hex2 = 7'b1111001; running=1. Each increment lands 3 clk after a tick rise.
- In RUN at 00:09, assert start_stop and tick on the same synchronised cycle -> 00:10, then state PAUSED. A further 5 ticks leave the count at 00:10. A second start_stop resumes, and the next tick gives 00:11.
- With MAX_MINUTES=2, run to 02:59, then one tick -> 00:00, wrap_pulse high for exactly 1 clk, running stays 1.
- At 00:42 in RUN, assert clear and tick together -> 00:00, IDLE. A clear held high for 100 clk yields a single clear. Asserting reset mid-count zeroes all outputs with no clk edge.
- With STOPWATCH_LAP_EN, lap at 00:20, then 10 ticks -> hex shows 00:20 and lap_active=1. A second lap -> display shows 00:30 and lap_active=0.

Source files
------------

// File: rtl/stopwatch_mmss.sv
// stopwatch_mmss: BCD MM:SS stopwatch driven by a synchronised 1 Hz tick, four active-low 7-seg digits.
// Optional lap-freeze display enabled by `define STOPWATCH_LAP_EN.  Rev 1.0
`default_nettype none

module stopwatch_mmss #(
  parameter int MAX_MINUTES = 59,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_in,
  input  logic       start_stop,
  input  logic       clear,
`ifdef STOPWATCH_LAP_EN
  input  logic       lap,
  output logic       lap_active,
`endif
  output logic [6:0] hex0,
  output logic [6:0] hex1,
  output logic [6:0] hex2,
  output logic [6:0] hex3,
  output logic       running,
  output logic       wrap_pulse
);

  localparam logic [3:0] MAX_MT = 4'(MAX_MINUTES / 10);
  localparam logic [3:0] MAX_MO = 4'(MAX_MINUTES % 10);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } state_t;

  state_t state;

  logic [SYNC_STAGES-1:0] tick_sync;
  logic                   tick_prev;
  logic [1:0]             ss_sync;
  logic                   ss_prev;
  logic [1:0]             clr_sync;
  logic                   clr_prev;

  logic sec_pulse;
  logic ss_pulse;
  logic clr_pulse;

  logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
  logic [3:0] disp_so, disp_st, disp_mo, disp_mt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_sync <= '0;
      tick_prev <= 1'b0;
      ss_sync   <= 2'b00;
      ss_prev   <= 1'b0;
      clr_sync  <= 2'b00;
      clr_prev  <= 1'b0;
    end else begin
      tick_sync <= {tick_sync[SYNC_STAGES-2:0], tick_in};
      tick_prev <= tick_sync[SYNC_STAGES-1];
      ss_sync   <= {ss_sync[0], start_stop};
      ss_prev   <= ss_sync[1];
      clr_sync  <= {clr_sync[0], clear};
      clr_prev  <= clr_sync[1];
    end
  end

  assign sec_pulse = tick_sync[SYNC_STAGES-1] & ~tick_prev;
  assign ss_pulse  = ss_sync[1] & ~ss_prev;
  assign clr_pulse = clr_sync[1] & ~clr_prev;

  // Clear wins outright; otherwise a tick in RUN is counted before a same-cycle pause takes effect.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      running    <= 1'b0;
      wrap_pulse <= 1'b0;
      sec_ones   <= 4'd0;
      sec_tens   <= 4'd0;
      min_ones   <= 4'd0;
      min_tens   <= 4'd0;
    end else begin
      wrap_pulse <= 1'b0;
      if (clr_pulse) begin
        state    <= IDLE;
        running  <= 1'b0;
        sec_ones <= 4'd0;
        sec_tens <= 4'd0;
        min_ones <= 4'd0;
        min_tens <= 4'd0;
      end else begin
        if (state == RUN && sec_pulse) begin
          if (sec_ones != 4'd9) begin
            sec_ones <= sec_ones + 4'd1;
          end else begin
            sec_ones <= 4'd0;
            if (sec_tens != 4'd5) begin
              sec_tens <= sec_tens + 4'd1;
            end else begin
              sec_tens <= 4'd0;
              if (min_tens == MAX_MT && min_ones == MAX_MO) begin
                min_tens   <= 4'd0;
                min_ones   <= 4'd0;
                wrap_pulse <= 1'b1;
              end else if (min_ones == 4'd9) begin
                min_ones <= 4'd0;
                min_tens <= min_tens + 4'd1;
              end else begin
                min_ones <= min_ones + 4'd1;
              end
            end
          end
        end
        if (ss_pulse) begin
          case (state)
            IDLE:    begin state <= RUN;    running <= 1'b1; end
            RUN:     begin state <= PAUSED; running <= 1'b0; end
            PAUSED:  begin state <= RUN;    running <= 1'b1; end
            default: begin state <= IDLE;   running <= 1'b0; end
          endcase
        end
      end
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic [1:0] lap_sync;
  logic       lap_prev;
  logic       lap_pulse;
  logic [3:0] lap_so, lap_st, lap_mo, lap_mt;

  assign lap_pulse = lap_sync[1] & ~lap_prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lap_sync   <= 2'b00;
      lap_prev   <= 1'b0;
      lap_active <= 1'b0;
      lap_so     <= 4'd0;
      lap_st     <= 4'd0;
      lap_mo     <= 4'd0;
      lap_mt     <= 4'd0;
    end else begin
      lap_sync <= {lap_sync[0], lap};
      lap_prev <= lap_sync[1];
      if (clr_pulse) begin
        lap_active <= 1'b0;
      end else if (lap_pulse && state == RUN) begin
        if (lap_active) begin
          lap_active <= 1'b0;
        end else begin
          lap_active <= 1'b1;
          lap_so     <= sec_ones;
          lap_st     <= sec_tens;
          lap_mo     <= min_ones;
          lap_mt     <= min_tens;
        end
      end
    end
  end

  assign disp_so = lap_active ? lap_so : sec_ones;
  assign disp_st = lap_active ? lap_st : sec_tens;
  assign disp_mo = lap_active ? lap_mo : min_ones;
  assign disp_mt = lap_active ? lap_mt : min_tens;
`else
  assign disp_so = sec_ones;
  assign disp_st = sec_tens;
  assign disp_mo = min_ones;
  assign disp_mt = min_tens;
`endif

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  assign hex0 = seg7(disp_so);
  assign hex1 = seg7(disp_st);
  assign hex2 = seg7(disp_mo);
  assign hex3 = seg7(disp_mt);

endmodule

`default_nettype wire

// File: tb/tb_stopwatch_mmss.sv
// tb_stopwatch_mmss: directed + randomised-timing bench against a seconds-count reference model.
// Lap checks compile in when STOPWATCH_LAP_EN is defined.  Rev 1.0
`default_nettype none
`timescale 1ns/1ps

module tb_stopwatch_mmss;

  localparam int MAXM  = 2;
  localparam int LIMIT = (MAXM + 1) * 60;

  logic       clk;
  logic       reset;
  logic       tick_in;
  logic       start_stop;
  logic       clear;
  logic [6:0] hex0, hex1, hex2, hex3;
  logic       running;
  logic       wrap_pulse;
`ifdef STOPWATCH_LAP_EN
  logic       lap;
  logic       lap_active;
`endif

  stopwatch_mmss #(.MAX_MINUTES(MAXM), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .tick_in    (tick_in),
    .start_stop (start_stop),
    .clear      (clear),
`ifdef STOPWATCH_LAP_EN
    .lap        (lap),
    .lap_active (lap_active),
`endif
    .hex0       (hex0),
    .hex1       (hex1),
    .hex2       (hex2),
    .hex3       (hex3),
    .running    (running),
    .wrap_pulse (wrap_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: elapsed seconds as one integer, state as 0=idle 1=run 2=paused
  int secs, st, frozen, exp_wrap;
  bit lap_on;
  int checks, errors;
  logic [6:0] seg_tab [10];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_disp(input string tag);
    int ds, m, s;
    ds = lap_on ? frozen : secs;
    m  = ds / 60;
    s  = ds % 60;
    chk({tag, ".hex0"}, 32'(hex0), 32'(seg_tab[s % 10]));
    chk({tag, ".hex1"}, 32'(hex1), 32'(seg_tab[s / 10]));
    chk({tag, ".hex2"}, 32'(hex2), 32'(seg_tab[m % 10]));
    chk({tag, ".hex3"}, 32'(hex3), 32'(seg_tab[m / 10]));
    chk({tag, ".running"}, 32'(running), 32'(st == 1));
`ifdef STOPWATCH_LAP_EN
    chk({tag, ".lap_active"}, 32'(lap_active), 32'(lap_on));
`endif
  endtask

  function automatic void model_tick();
    exp_wrap = 0;
    if (st == 1) begin
      exp_wrap = (secs == LIMIT - 1);
      secs = (secs + 1) % LIMIT;
    end
  endfunction

  function automatic void model_ss();
    st = (st == 1) ? 2 : 1;
  endfunction

  function automatic void model_clear();
    secs = 0; st = 0; lap_on = 0;
  endfunction

  // Count changes exactly on the third clk edge after the tick rises
  task automatic do_tick(input string tag);
    tick_in = 1'b1;
    step(2);
    check_disp({tag, ".pre"});
    chk({tag, ".wrap_pre"}, 32'(wrap_pulse), 0);
    step(1);
    model_tick();
    check_disp({tag, ".post"});
    chk({tag, ".wrap"}, 32'(wrap_pulse), 32'(exp_wrap));
    step(1);
    chk({tag, ".wrap_after"}, 32'(wrap_pulse), 0);
    step($urandom_range(0, 2));
    tick_in = 1'b0;
    step($urandom_range(4, 7));
  endtask

  task automatic ticks(input int n, input string tag);
    for (int i = 0; i < n; i++) do_tick(tag);
  endtask

  task automatic press_ss(input string tag);
    start_stop = 1'b1;
    step(2);
    check_disp({tag, ".pre"});
    step(1);
    model_ss();
    check_disp({tag, ".post"});
    step($urandom_range(1, 4));
    start_stop = 1'b0;
    step($urandom_range(4, 6));
  endtask

  task automatic press_clear(input string tag);
    clear = 1'b1;
    step(3);
    model_clear();
    check_disp(tag);
    step($urandom_range(1, 4));
    clear = 1'b0;
    step($urandom_range(4, 6));
  endtask

  task automatic ss_and_tick(input string tag);
    start_stop = 1'b1;
    tick_in    = 1'b1;
    step(3);
    model_tick();
    model_ss();
    check_disp(tag);
    step(2);
    start_stop = 1'b0;
    tick_in    = 1'b0;
    step(5);
  endtask

  task automatic clear_and_tick(input string tag);
    clear   = 1'b1;
    tick_in = 1'b1;
    step(3);
    model_clear();
    check_disp(tag);
    chk({tag, ".wrap"}, 32'(wrap_pulse), 0);
    step(2);
    clear   = 1'b0;
    tick_in = 1'b0;
    step(5);
  endtask

`ifdef STOPWATCH_LAP_EN
  task automatic press_lap(input string tag);
    lap = 1'b1;
    step(3);
    if (st == 1) begin
      if (lap_on) lap_on = 0;
      else begin lap_on = 1; frozen = secs; end
    end
    check_disp(tag);
    step(2);
    lap = 1'b0;
    step(5);
  endtask
`endif

  initial begin
    int n;
    seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    checks = 0; errors = 0;
    secs = 0; st = 0; frozen = 0; lap_on = 0; exp_wrap = 0;
    reset = 1'b0; tick_in = 1'b0; start_stop = 1'b0; clear = 1'b0;
`ifdef STOPWATCH_LAP_EN
    lap = 1'b0;
`endif
    step(3);
    check_disp("reset");
    chk("reset.wrap", 32'(wrap_pulse), 0);
    reset = 1'b1;
    step(2);

    ticks(3, "idle_tick");
    chk("idle.hex0", 32'(hex0), 32'h40);

    press_ss("start");
    ticks(75, "run75");
    check_disp("at_01_15");
    chk("at_01_15.hex2", 32'(hex2), 32'h79);

    press_clear("clr1");
    press_ss("start2");
    ticks(9, "to09");
    ss_and_tick("ss_tick");
    ticks(5, "paused_tick");
    press_ss("resume");
    do_tick("after_resume");
    n = $urandom_range(5, 30);
    ticks(n, "rand_run");
    press_ss("pause_rand");
    ticks($urandom_range(1, 4), "rand_paused");
    press_ss("resume_rand");

    press_clear("clr_wrap");
    press_ss("start_wrap");
    ticks(LIMIT - 1, "to_max");
    check_disp("at_02_59");
    do_tick("wrap_tick");
    ticks(2, "after_wrap");

    press_clear("clr42");
    press_ss("start42");
    ticks(42, "to42");
    clear_and_tick("clr_tick");

    press_ss("start_hold");
    ticks(3, "pre_hold");
    clear = 1'b1;
    step(3);
    model_clear();
    check_disp("hold_clr");
    press_ss("hold_start");
    do_tick("hold_tick");
    step(75);
    check_disp("hold_still");
    clear = 1'b0;
    step(5);
    check_disp("hold_release");

    ticks($urandom_range(3, 8), "pre_reset");
    #2;
    reset = 1'b0;
    #1;
    model_clear();
    check_disp("async_reset");
    chk("async_reset.wrap", 32'(wrap_pulse), 0);
    step(2);
    reset = 1'b1;
    step(2);
    check_disp("after_reset");

`ifdef STOPWATCH_LAP_EN
    press_ss("lap_start");
    ticks(20, "lap_to20");
    press_lap("lap_freeze");
    ticks(10, "lap_frozen");
    check_disp("lap_shows20");
    press_lap("lap_release");
    check_disp("lap_shows30");
    press_lap("lap_freeze2");
    ticks(2, "lap_frozen2");
    press_clear("lap_clr");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
